thermo_to_bin: RTL and testbench

Converts a 15-bit thermometer code into a 4-bit binary count, for example from a flash-ADC comparator bank or a pooling-filter threshold stage. A combinational path gives a zero-latency result. A registered path adds a one-cycle result, a bubble (malformed code) flag and a saturating bubble counter for monitoring. The block sits between the thermometer source and the downstream binary datapath.

---
 rtl/thermo_to_bin.sv | 50 +++++
 tb/tb_thermo_to_bin.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/thermo_to_bin.sv
// Thermometer-to-binary converter: zero-latency popcount and bubble flag, plus a
// one-cycle registered copy with a saturating bubble counter for monitoring.
module thermo_to_bin #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [14:0]      thermo,
    input  logic             in_valid,
    output logic [3:0]       bin,
    output logic             bubble,
    output logic [3:0]       bin_q,
    output logic             valid_q,
    output logic             bubble_q,
    output logic [CNT_W-1:0] bubble_cnt
);

    logic [14:0] thermo_inc;

    // Ones-count rather than priority encode, so a single bubble costs at most one LSB.
    always_comb begin
        bin = 4'd0;
        for (int i = 0; i < 15; i++) begin
            bin = bin + {3'd0, thermo[i]};
        end
    end

    // A valid code plus one is a single power of two with no overlap; 0x7FFF wraps to 0.
    assign thermo_inc = thermo + 15'd1;
    assign bubble     = |(thermo & thermo_inc);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            bin_q      <= 4'd0;
            valid_q    <= 1'b0;
            bubble_q   <= 1'b0;
            bubble_cnt <= '0;
        end else begin
            valid_q <= in_valid;
            if (in_valid) begin
                bin_q    <= bin;
                bubble_q <= bubble;
                if (bubble && (bubble_cnt != {CNT_W{1'b1}})) begin
                    bubble_cnt <= bubble_cnt + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_thermo_to_bin.sv
// Bench for thermo_to_bin: direct checks of the combinational path and reset state,
// scoreboard queue plus monitor for the registered path (counter width 2).
module tb_thermo_to_bin;

    logic        clk;
    logic        rst_n;
    logic [14:0] thermo;
    logic        in_valid;
    logic [3:0]  bin;
    logic        bubble;
    logic [3:0]  bin_q;
    logic        valid_q;
    logic        bubble_q;
    logic [1:0]  bubble_cnt;

    int n_checks = 0;
    int n_errors = 0;

    // Expected registered result: {bin_q, bubble_q, bubble_cnt}
    logic [6:0] exp_q[$];

    thermo_to_bin #(.CNT_W(2)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .thermo     (thermo),
        .in_valid   (in_valid),
        .bin        (bin),
        .bubble     (bubble),
        .bin_q      (bin_q),
        .valid_q    (valid_q),
        .bubble_q   (bubble_q),
        .bubble_cnt (bubble_cnt)
    );

    // Clock and watchdog
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required $finish earlier");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input int act, input int req);
        n_checks++;
        if (act != req) begin
            n_errors++;
            $display("FAIL %s: actual %0d required %0d", name, act, req);
        end
    endtask

    task automatic chk_comb(input logic [14:0] t, input logic [3:0] eb, input logic ebub);
        @(negedge clk);
        thermo   = t;
        in_valid = 1'b0;
        #1;
        check($sformatf("bin[%h]", t), int'(bin), int'(eb));
        check($sformatf("bubble[%h]", t), int'(bubble), int'(ebub));
    endtask

    task automatic send(input logic [14:0] t, input logic [3:0] eb, input logic ebub,
                        input logic [1:0] ec);
        @(negedge clk);
        thermo   = t;
        in_valid = 1'b1;
        exp_q.push_back({eb, ebub, ec});
        @(posedge clk);
    endtask

    task automatic idle();
        @(negedge clk);
        in_valid = 1'b0;
        @(posedge clk);
    endtask

    // Monitor: every presented registered result is popped and compared
    always @(negedge clk) begin
        if (valid_q) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL mon_unexpected: actual valid_q=1 required no output");
            end else begin
                logic [6:0] e;
                e = exp_q.pop_front();
                check("mon_bin_q", int'(bin_q), int'(e[6:3]));
                check("mon_bubble_q", int'(bubble_q), int'(e[2]));
                check("mon_bubble_cnt", int'(bubble_cnt), int'(e[1:0]));
            end
        end
    end

    initial begin
        logic [15:0] tmp;
        rst_n    = 1'b0;
        thermo   = 15'd0;
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_bin_q", int'(bin_q), 0);
        check("rst_valid_q", int'(valid_q), 0);
        check("rst_bubble_q", int'(bubble_q), 0);
        check("rst_bubble_cnt", int'(bubble_cnt), 0);

        // Combinational path, exercised while still in reset
        chk_comb(15'h0001, 4'd1, 1'b0);
        chk_comb(15'h0003, 4'd2, 1'b0);
        for (int n = 0; n <= 15; n++) begin
            tmp = (16'd1 << n) - 16'd1;
            chk_comb(tmp[14:0], 4'(n), 1'b0);
        end
        chk_comb(15'h0005, 4'd2, 1'b1);
        chk_comb(15'h4000, 4'd1, 1'b1);
        chk_comb(15'h7FFE, 4'd14, 1'b1);
        chk_comb(15'h5555, 4'd8, 1'b1);

        // Registered path
        @(negedge clk);
        rst_n = 1'b1;
        send(15'h00FF, 4'd8, 1'b0, 2'd0);
        idle();
        @(negedge clk);
        check("hold_valid_q", int'(valid_q), 0);
        check("hold_bin_q", int'(bin_q), 8);
        check("hold_bubble_q", int'(bubble_q), 0);

        // Saturation with a 2-bit counter: 1,2,3,3,3
        send(15'h0005, 4'd2, 1'b1, 2'd1);
        send(15'h4000, 4'd1, 1'b1, 2'd2);
        send(15'h7FFE, 4'd14, 1'b1, 2'd3);
        send(15'h0005, 4'd2, 1'b1, 2'd3);
        send(15'h0101, 4'd2, 1'b1, 2'd3);
        send(15'h7FFF, 4'd15, 1'b0, 2'd3);
        idle();

        // Mid-stream reset with the counter at 2
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        send(15'h0006, 4'd2, 1'b1, 2'd1);
        send(15'h001F, 4'd5, 1'b0, 2'd1);
        send(15'h0300, 4'd2, 1'b1, 2'd2);
        @(negedge clk);
        rst_n    = 1'b0;
        thermo   = 15'h0005;
        in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("midrst_bin_q", int'(bin_q), 0);
        check("midrst_valid_q", int'(valid_q), 0);
        check("midrst_bubble_q", int'(bubble_q), 0);
        check("midrst_bubble_cnt", int'(bubble_cnt), 0);
        rst_n    = 1'b1;
        in_valid = 1'b0;
        send(15'h0007, 4'd3, 1'b0, 2'd0);
        idle();

        repeat (3) @(posedge clk);
        check("queue_drained", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
